// File: rtl/spi_target_lite_if.sv
// FIFO-side stream handshakes of spi_target_lite: RX bytes out, TX bytes in.
// The DUT uses the slave modport; the system side uses the master modport.
interface spi_target_lite_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport slave (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_valid
    );

    modport master (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/spi_target_lite.sv
// SPI mode-0 target with oversampled SCK/CS/COPI and RX/TX byte FIFOs.
// Optional macro SPI_TARGET_STATUS_EN: first byte of each transaction is a status byte.
module spi_target_lite #(
    parameter int unsigned RxDepth    = 4,
    parameter int unsigned TxDepth    = 4,
    parameter logic [7:0]  IdleByte   = 8'hFF,
    parameter int unsigned SyncStages = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               spi_sck_i,
    input  logic               spi_cs_ni,
    input  logic               spi_copi_i,
    output logic               spi_cipo_o,
    output logic               spi_cipo_en_o,
    spi_target_lite_if.slave   fifo_if,
    output logic               active_o,
    output logic               rx_overflow_o,
    output logic               tx_underflow_o,
    input  logic               err_clr_i
);
    localparam int unsigned RxAw = $clog2(RxDepth);
    localparam int unsigned TxAw = $clog2(TxDepth);
    localparam int unsigned RxCw = RxAw + 1;
    localparam int unsigned TxCw = TxAw + 1;
    localparam logic [RxCw-1:0] RxFullCnt = RxCw'(RxDepth);
    localparam logic [TxCw-1:0] TxFullCnt = TxCw'(TxDepth);

    typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

    logic [SyncStages-1:0] sck_sync_q, cs_sync_q, copi_sync_q;
    logic                  sck_dly_q, cs_dly_q;
    logic                  sck_s, cs_s, copi_s;
    logic                  sck_rise, sck_fall, cs_fall, cs_rise;

    state_e     state_q, state_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic       idle_q, idle_d;
    logic       ovf_q, ovf_d, unf_q, unf_d;
    logic       load_req, rx_push_req, unf_set;
    logic [7:0] rx_push_data;

    logic [7:0]      rx_mem_q [RxDepth];
    logic [RxAw-1:0] rx_wr_q, rx_rd_q;
    logic [RxCw-1:0] rx_cnt_q;
    logic            rx_full, rx_empty, rx_push, rx_pop, rx_drop;

    logic [7:0]      tx_mem_q [TxDepth];
    logic [TxAw-1:0] tx_wr_q, tx_rd_q;
    logic [TxCw-1:0] tx_cnt_q;
    logic            tx_full, tx_empty, tx_push, tx_pop;

    assign sck_s    = sck_sync_q[SyncStages-1];
    assign cs_s     = cs_sync_q[SyncStages-1];
    assign copi_s   = copi_sync_q[SyncStages-1];
    assign sck_rise = sck_s & ~sck_dly_q;
    assign sck_fall = ~sck_s & sck_dly_q;
    assign cs_fall  = ~cs_s & cs_dly_q;
    assign cs_rise  = cs_s & ~cs_dly_q;

    assign rx_full  = (rx_cnt_q == RxFullCnt);
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_pop   = ~rx_empty & fifo_if.rx_ready;
    assign rx_push  = rx_push_req & (~rx_full | rx_pop);
    assign rx_drop  = rx_push_req & rx_full & ~rx_pop;

    assign tx_full  = (tx_cnt_q == TxFullCnt);
    assign tx_empty = (tx_cnt_q == '0);
    assign tx_push  = fifo_if.tx_valid & ~tx_full;
    assign tx_pop   = load_req & ~tx_empty;

    assign rx_push_data = {rx_shift_q[6:0], copi_s};

`ifdef SPI_TARGET_STATUS_EN
    logic [3:0] tx_cnt_sat;
    logic [7:0] status_byte;
    assign tx_cnt_sat  = (32'(tx_cnt_q) > 32'd15) ? 4'hF : 4'(tx_cnt_q);
    assign status_byte = {ovf_q, unf_q, rx_full, tx_empty, tx_cnt_sat};
`endif

    always_comb begin
        state_d     = state_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        bit_cnt_d   = bit_cnt_q;
        idle_d      = idle_q;
        load_req    = 1'b0;
        rx_push_req = 1'b0;
        unf_set     = 1'b0;
        case (state_q)
            StIdle: if (cs_fall) state_d = StLoad;
            StLoad: begin
                bit_cnt_d = '0;
                state_d   = StShift;
`ifdef SPI_TARGET_STATUS_EN
                tx_shift_d = status_byte;
                idle_d     = 1'b0;
`else
                load_req = 1'b1;
`endif
            end
            StShift: begin
                if (sck_rise) begin
                    rx_shift_d  = rx_push_data;
                    bit_cnt_d   = bit_cnt_q + 4'd1;
                    rx_push_req = (bit_cnt_q == 4'd7);
                    // Underflow is flagged when an idle byte actually starts going out.
                    unf_set     = (bit_cnt_q == 4'd0) & idle_q;
                end else if (sck_fall) begin
                    if (bit_cnt_q == 4'd8) begin
                        load_req  = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (cs_rise) begin
            state_d     = StIdle;
            load_req    = 1'b0;
            rx_push_req = 1'b0;
            unf_set     = 1'b0;
        end
        if (load_req) begin
            tx_shift_d = tx_empty ? IdleByte : tx_mem_q[tx_rd_q];
            idle_d     = tx_empty;
        end
    end

    assign ovf_d = ~err_clr_i & (ovf_q | rx_drop);
    assign unf_d = ~err_clr_i & (unf_q | unf_set);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            copi_sync_q <= '0;
            sck_dly_q   <= 1'b0;
            cs_dly_q    <= 1'b1;
            state_q     <= StIdle;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            idle_q      <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            rx_wr_q     <= '0;
            rx_rd_q     <= '0;
            rx_cnt_q    <= '0;
            tx_wr_q     <= '0;
            tx_rd_q     <= '0;
            tx_cnt_q    <= '0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SyncStages-2:0], spi_sck_i};
            cs_sync_q   <= {cs_sync_q[SyncStages-2:0], spi_cs_ni};
            copi_sync_q <= {copi_sync_q[SyncStages-2:0], spi_copi_i};
            sck_dly_q   <= sck_s;
            cs_dly_q    <= cs_s;
            state_q     <= state_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            idle_q      <= idle_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            if (rx_push) rx_wr_q <= rx_wr_q + RxAw'(1);
            if (rx_pop)  rx_rd_q <= rx_rd_q + RxAw'(1);
            rx_cnt_q <= rx_cnt_q + RxCw'(rx_push) - RxCw'(rx_pop);
            if (tx_push) tx_wr_q <= tx_wr_q + TxAw'(1);
            if (tx_pop)  tx_rd_q <= tx_rd_q + TxAw'(1);
            tx_cnt_q <= tx_cnt_q + TxCw'(tx_push) - TxCw'(tx_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rx_push) rx_mem_q[rx_wr_q] <= rx_push_data;
        if (tx_push) tx_mem_q[tx_wr_q] <= fifo_if.tx_data;
    end

    assign fifo_if.rx_data  = rx_empty ? 8'h00 : rx_mem_q[rx_rd_q];
    assign fifo_if.rx_valid = ~rx_empty;
    assign fifo_if.tx_ready = ~tx_full;
    assign spi_cipo_o       = (state_q == StShift) & tx_shift_q[7];
    assign spi_cipo_en_o    = (state_q == StShift);
    assign active_o         = (state_q != StIdle);
    assign rx_overflow_o    = ovf_q;
    assign tx_underflow_o   = unf_q;
endmodule

// File: tb/tb_spi_target_lite.sv
// Bench for spi_target_lite: directed vector table, hand-written abort/reset sequences and
// randomized transactions checked against a queue-based model.
module tb_spi_target_lite;
    localparam int RxDepth    = 4;
    localparam int TxDepth    = 4;
    localparam int SyncStages = 2;
    localparam logic [7:0] IdleByte = 8'hFF;

    logic clk = 1'b0, rst_n = 1'b0, sck = 1'b0, cs_n = 1'b1, copi = 1'b0, err_clr = 1'b0;
    logic cipo, cipo_en, active, ovf, unf;

    spi_target_lite_if fif ();

    spi_target_lite #(
        .RxDepth(RxDepth), .TxDepth(TxDepth), .IdleByte(IdleByte), .SyncStages(SyncStages)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .spi_sck_i(sck), .spi_cs_ni(cs_n), .spi_copi_i(copi),
        .spi_cipo_o(cipo), .spi_cipo_en_o(cipo_en), .fifo_if(fif), .active_o(active),
        .rx_overflow_o(ovf), .tx_underflow_o(unf), .err_clr_i(err_clr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: FIFO contents as queues plus the two sticky flags.
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic       m_ovf, m_unf;

    task automatic m_load(output logic [7:0] b, output logic idle);
        if (txq.size() > 0) begin
            b = txq.pop_front();
            idle = 1'b0;
        end else begin
            b = IdleByte;
            idle = 1'b1;
        end
    endtask

`ifdef SPI_TARGET_STATUS_EN
    function automatic logic [7:0] m_status();
        int c = txq.size();
        if (c > 15) c = 15;
        return {m_ovf, m_unf, rxq.size() == RxDepth, txq.size() == 0, 4'(c)};
    endfunction
`endif

    logic [7:0] h_mosi [8];
    logic [7:0] h_miso [8];
    logic [7:0] exp_miso [8];

    task automatic do_reset();
        rst_n = 1'b0; sck = 1'b0; cs_n = 1'b1; copi = 1'b0; err_clr = 1'b0;
        fif.rx_ready = 1'b0; fif.tx_valid = 1'b0; fif.tx_data = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        txq.delete(); rxq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    // One SCK period (clk/8): COPI set during low phase, CIPO sampled just before the rise.
    task automatic sck_bit(input logic b, output logic c);
        copi = b;
        repeat (4) @(negedge clk);
        c = cipo;
        sck = 1'b1;
        repeat (4) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic host_xfer(input int nb, input int extra);
        logic c;
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nb; i++)
            for (int b = 7; b >= 0; b--) begin
                sck_bit(h_mosi[i][b], c);
                h_miso[i][b] = c;
            end
        for (int b = 0; b < extra; b++) sck_bit(h_mosi[nb][7-b], c);
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic push_tx(input logic [7:0] b);
        fif.tx_data = b;
        fif.tx_valid = 1'b1;
        chk("tx_ready", fif.tx_ready, txq.size() < TxDepth);
        if (txq.size() < TxDepth) txq.push_back(b);
        @(negedge clk);
        fif.tx_valid = 1'b0;
    endtask

    task automatic pop_rx(input string name, input logic [7:0] exp);
        chk({name, "_valid"}, fif.rx_valid, 1);
        chk({name, "_data"}, fif.rx_data, exp);
        fif.rx_ready = 1'b1;
        @(negedge clk);
        fif.rx_ready = 1'b0;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_ovf = 1'b0; m_unf = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_rx_valid"}, fif.rx_valid, 0);
        chk({tag, "_rx_data"}, fif.rx_data, 0);
        chk({tag, "_tx_ready"}, fif.tx_ready, 1);
        chk({tag, "_cipo"}, cipo, 0);
        chk({tag, "_cipo_en"}, cipo_en, 0);
        chk({tag, "_active"}, active, 0);
        chk({tag, "_ovf"}, ovf, 0);
        chk({tag, "_unf"}, unf, 0);
    endtask

    task automatic rand_txn(input int t);
        int npush = $urandom_range(0, 5);
        int nb, extra, ndrain;
        logic [7:0] cur;
        logic idle;
        for (int i = 0; i < npush; i++) push_tx(8'($urandom));
        if ($urandom_range(0, 3) == 0) clear_err();
        nb = $urandom_range(1, 3);
        extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
        for (int i = 0; i <= nb; i++) h_mosi[i] = 8'($urandom);
`ifdef SPI_TARGET_STATUS_EN
        cur = m_status();
        idle = 1'b0;
`else
        m_load(cur, idle);
`endif
        for (int i = 0; i < nb; i++) begin
            exp_miso[i] = cur;
            if (idle) m_unf = 1'b1;
            if (rxq.size() < RxDepth) rxq.push_back(h_mosi[i]);
            else m_ovf = 1'b1;
            m_load(cur, idle);
        end
        if (extra > 0 && idle) m_unf = 1'b1;
        host_xfer(nb, extra);
        for (int i = 0; i < nb; i++)
            chk($sformatf("rnd%0d_miso%0d", t, i), h_miso[i], exp_miso[i]);
        chk($sformatf("rnd%0d_ovf", t), ovf, m_ovf);
        chk($sformatf("rnd%0d_unf", t), unf, m_unf);
        chk($sformatf("rnd%0d_rx_valid", t), fif.rx_valid, rxq.size() != 0);
        ndrain = $urandom_range(0, rxq.size());
        for (int i = 0; i < ndrain; i++) pop_rx($sformatf("rnd%0d_rx", t), rxq.pop_front());
    endtask

    typedef struct packed {
        int             ntx;
        logic [3:0][7:0] tx;
        int             nb;
        logic [4:0][7:0] mosi;
        logic [4:0][7:0] miso;
        int             nrx;
        logic [4:0][7:0] rx;
        logic           ovf;
        logic           unf;
    } row_t;

    row_t rows [4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] pat;
        logic c;
        int k;

        rows[0] = '{ntx: 2, tx: {8'h00, 8'h00, 8'h3C, 8'hA5}, nb: 2,
                    mosi: {8'h00, 8'h00, 8'h00, 8'h34, 8'h12},
                    miso: {8'h00, 8'h00, 8'h00, 8'h3C, 8'hA5}, nrx: 2,
                    rx: {8'h00, 8'h00, 8'h00, 8'h34, 8'h12}, ovf: 1'b0, unf: 1'b0};
        rows[1] = '{ntx: 0, tx: '0, nb: 1, mosi: '0,
                    miso: {8'h00, 8'h00, 8'h00, 8'h00, 8'hFF}, nrx: 1, rx: '0,
                    ovf: 1'b0, unf: 1'b1};
        rows[2] = '{ntx: 0, tx: '0, nb: 5, mosi: {8'h05, 8'h04, 8'h03, 8'h02, 8'h01},
                    miso: {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, nrx: 4,
                    rx: {8'h00, 8'h04, 8'h03, 8'h02, 8'h01}, ovf: 1'b1, unf: 1'b1};
        rows[3] = '{ntx: 3, tx: {8'h00, 8'h33, 8'h22, 8'h11}, nb: 2,
                    mosi: {8'h00, 8'h00, 8'h00, 8'h55, 8'hAA},
                    miso: {8'h00, 8'h00, 8'h00, 8'h22, 8'h11}, nrx: 2,
                    rx: {8'h00, 8'h00, 8'h00, 8'h55, 8'hAA}, ovf: 1'b0, unf: 1'b0};
`ifdef SPI_TARGET_STATUS_EN
        rows[0].miso = {8'h00, 8'h00, 8'h00, 8'hA5, 8'h02};
        rows[1].miso = {8'h00, 8'h00, 8'h00, 8'h00, 8'h10};
        rows[1].unf  = 1'b0;
        rows[2].miso = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h10};
        rows[3].miso = {8'h00, 8'h00, 8'h00, 8'h11, 8'h03};
`endif

        do_reset();
        check_idle_outputs("reset");

        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < rows[r].ntx; i++) push_tx(rows[r].tx[i]);
            for (int i = 0; i < rows[r].nb; i++) h_mosi[i] = rows[r].mosi[i];
            host_xfer(rows[r].nb, 0);
            for (int i = 0; i < rows[r].nb; i++)
                chk($sformatf("row%0d_miso%0d", r, i), h_miso[i], rows[r].miso[i]);
            chk($sformatf("row%0d_ovf", r), ovf, rows[r].ovf);
            chk($sformatf("row%0d_unf", r), unf, rows[r].unf);
            for (int i = 0; i < rows[r].nrx; i++)
                pop_rx($sformatf("row%0d_rx%0d", r, i), rows[r].rx[i]);
            chk($sformatf("row%0d_rx_drained", r), fif.rx_valid, 0);
            clear_err();
            chk($sformatf("row%0d_ovf_clr", r), ovf, 0);
            chk($sformatf("row%0d_unf_clr", r), unf, 0);
        end

        // CS raised after 5 bits: no push, CIPO disabled promptly, next byte starts at bit 0.
        do_reset();
        push_tx(8'h5A);
        push_tx(8'hC3);
        pat = 8'hB0;
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int b = 7; b >= 3; b--) sck_bit(pat[b], c);
        repeat (2) @(negedge clk);
        cs_n = 1'b1;
        for (k = 1; k <= SyncStages + 2; k++) begin
            @(negedge clk);
            if (!cipo_en) break;
        end
        chk("abort_cipo_en", cipo_en, 0);
        repeat (8) @(negedge clk);
        chk("abort_no_push", fif.rx_valid, 0);
        chk("abort_active", active, 0);
        h_mosi[0] = 8'h77;
        h_mosi[1] = 8'h5E;
`ifdef SPI_TARGET_STATUS_EN
        host_xfer(2, 0);
        chk("abort_next_status", h_miso[0], 8'h02);
        chk("abort_next_miso", h_miso[1], 8'h5A);
`else
        host_xfer(1, 0);
        chk("abort_next_miso", h_miso[0], 8'hC3);
`endif
        pop_rx("abort_next_rx", 8'h77);

        // Reset pulse in the middle of a byte with flags and FIFOs populated.
        do_reset();
        h_mosi[0] = 8'h3C;
        host_xfer(1, 0);
`ifndef SPI_TARGET_STATUS_EN
        chk("pre_reset_unf", unf, 1);
`endif
        push_tx(8'hA1);
        pat = 8'h96;
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int b = 7; b >= 4; b--) sck_bit(pat[b], c);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("midbyte_reset");
        rst_n = 1'b1;
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        check_idle_outputs("after_reset");

        do_reset();
        for (int t = 0; t < 24; t++) rand_txn(t);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
